prim_fetch: RTL and testbench

- Reads primitive records out of the vertex RAM after the ROM-to-RAM load completes.
- Presents one 4-word record per transfer to the line/triangle rasterizer over a valid/ready handshake.
- Sits between the RAM's 4-word read port and the rasterizer front end; it is the consumer/reader counterpart of the loader that fills the RAM.

---
 rtl/prim_fetch.sv | 91 +++++++++
 tb/tb_prim_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/prim_fetch.sv
// prim_fetch: reads 4-word primitive records from vertex RAM and presents them over valid/ready.
// Optional PRIM_FETCH_CHECKSUM_EN adds an XOR checksum of all accepted records.
module prim_fetch #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int STRIDE = 4,
  parameter logic [DATA_WIDTH-1:0] END_MARKER = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] prim_count,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_read_data1,
  input  logic [DATA_WIDTH-1:0] ram_read_data2,
  input  logic [DATA_WIDTH-1:0] ram_read_data3,
  input  logic [DATA_WIDTH-1:0] ram_read_data4,
  output logic                  prim_valid,
  input  logic                  prim_ready,
  output logic [DATA_WIDTH-1:0] prim_w0,
  output logic [DATA_WIDTH-1:0] prim_w1,
  output logic [DATA_WIDTH-1:0] prim_w2,
  output logic [DATA_WIDTH-1:0] prim_w3,
  output logic [ADDR_WIDTH-1:0] prim_index,
  output logic                  busy,
  output logic                  done
`ifdef PRIM_FETCH_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] checksum
`else
`endif
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, PRESENT, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(STRIDE);
  state_t state, next;
  logic [ADDR_WIDTH-1:0] addr, count, index_next;
  logic launch, hs, last;
  assign launch = state == IDLE && start;
  assign hs = prim_valid && prim_ready;
  assign index_next = prim_index + 1'b1;
  assign last = index_next == count;
  assign prim_valid = state == PRESENT;
  assign busy = state == FETCH || state == CAPTURE || state == PRESENT;
  assign done = state == DONE;
  assign ram_read_addr = (state == FETCH || state == CAPTURE) ? addr : '0;
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (start) next = prim_count != '0 ? FETCH : DONE;
      FETCH:   next = CAPTURE;
      CAPTURE: next = ram_read_data1 == END_MARKER ? DONE : PRESENT;
      PRESENT: if (prim_ready) next = last ? DONE : FETCH;
      DONE:    if (!start) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      addr <= '0;
      count <= '0;
      prim_index <= '0;
      prim_w0 <= '0;
      prim_w1 <= '0;
      prim_w2 <= '0;
      prim_w3 <= '0;
    end else begin
      if (launch) begin
        count <= prim_count;
        addr <= '0;
        prim_index <= '0;
      end
      if (state == CAPTURE) begin
        prim_w0 <= ram_read_data1;
        prim_w1 <= ram_read_data2;
        prim_w2 <= ram_read_data3;
        prim_w3 <= ram_read_data4;
      end
      if (hs && !last) begin
        addr <= addr + STEP;
        prim_index <= index_next;
      end
    end
`ifdef PRIM_FETCH_CHECKSUM_EN
  always_ff @(posedge clk)
    if (reset || launch) checksum <= '0;
    else if (hs) checksum <= checksum ^ prim_w0 ^ prim_w1 ^ prim_w2 ^ prim_w3;
`else
`endif
endmodule

// File: tb/tb_prim_fetch.sv
// tb_prim_fetch: directed test-plan steps plus randomized lists checked against a record-list model.
module tb_prim_fetch;
  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;
  logic clk = 0, reset = 1, start = 0, prim_ready = 0;
  logic [7:0] prim_count = 0;
  logic [7:0] ram_read_addr, prim_index;
  logic [31:0] rd1, rd2, rd3, rd4, prim_w0, prim_w1, prim_w2, prim_w3;
  logic prim_valid, busy, done;
  logic [31:0] ram [256];
  int compared = 0, mismatched = 0;
`ifdef PRIM_FETCH_CHECKSUM_EN
  logic [31:0] checksum;
`endif
  assign rd1 = ram[ram_read_addr];
  assign rd2 = ram[ram_read_addr + 8'd1];
  assign rd3 = ram[ram_read_addr + 8'd2];
  assign rd4 = ram[ram_read_addr + 8'd3];
  always #5 clk = ~clk;
  prim_fetch dut (
    .clk(clk), .reset(reset), .start(start), .prim_count(prim_count),
    .ram_read_addr(ram_read_addr), .ram_read_data1(rd1), .ram_read_data2(rd2),
    .ram_read_data3(rd3), .ram_read_data4(rd4), .prim_valid(prim_valid),
    .prim_ready(prim_ready), .prim_w0(prim_w0), .prim_w1(prim_w1), .prim_w2(prim_w2),
    .prim_w3(prim_w3), .prim_index(prim_index), .busy(busy), .done(done)
`ifdef PRIM_FETCH_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [127:0] rec;
    return {prim_w0, prim_w1, prim_w2, prim_w3};
  endfunction
  logic [127:0] exp_q [$];
  logic [127:0] r;
  logic [31:0] exp_sum;
  int n, got, cyc;
  initial begin
    for (int a = 0; a < 256; a++) ram[a] = 0;
    for (int a = 0; a < 8; a++) ram[a] = a + 1;
    tick;
    tick;
    chk("rst_valid", prim_valid, 0);
    chk("rst_busy_done", {busy, done}, 0);
    chk("rst_addr", ram_read_addr, 0);
    chk("rst_words", rec(), 0);
    chk("rst_index", prim_index, 0);
`ifdef PRIM_FETCH_CHECKSUM_EN
    chk("rst_checksum", checksum, 0);
`endif
    reset = 0;
    // two records, ready tied high
    start = 1; prim_count = 2; prim_ready = 1;
    tick;
    chk("s1_busy", busy, 1);
    chk("s1_fetch_addr", ram_read_addr, 0);
    tick;
    chk("s1_valid_c2", prim_valid, 0);
    tick;
    chk("s1_valid_c3", prim_valid, 1);
    chk("s1_rec0", rec(), {32'd1, 32'd2, 32'd3, 32'd4});
    chk("s1_idx0", prim_index, 0);
    tick;
    chk("s1_valid_c4", prim_valid, 0);
    tick;
    chk("s1_addr4", ram_read_addr, 4);
    tick;
    chk("s1_valid_c6", prim_valid, 1);
    chk("s1_rec1", rec(), {32'd5, 32'd6, 32'd7, 32'd8});
    chk("s1_idx1", prim_index, 1);
    tick;
    chk("s1_done", {done, busy, prim_valid}, 3'b100);
    chk("s1_done_addr", ram_read_addr, 0);
`ifdef PRIM_FETCH_CHECKSUM_EN
    chk("s1_checksum", checksum, 8);
`endif
    tick;
    chk("s1_done_hold", done, 1);
    start = 0;
    tick;
    chk("s1_idle", done, 0);
    // backpressure
    start = 1; prim_ready = 0;
    tick; tick; tick;
    chk("s2_valid", prim_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("s2_hold_valid", prim_valid, 1);
      chk("s2_hold_rec", rec(), {32'd1, 32'd2, 32'd3, 32'd4});
    end
    prim_ready = 1;
    tick;
    chk("s2_hs", prim_valid, 0);
    tick;
    chk("s2_c2", prim_valid, 0);
    tick;
    chk("s2_rec1", {prim_valid, rec()}, {1'b1, 32'd5, 32'd6, 32'd7, 32'd8});
    tick;
    chk("s2_done", done, 1);
    start = 0;
    tick;
    // end marker
    ram[4] = END_MARKER;
    start = 1; prim_count = 3;
    tick; tick; tick;
    chk("s3_rec0", {prim_valid, rec()}, {1'b1, 32'd1, 32'd2, 32'd3, 32'd4});
    tick; tick;
    chk("s3_capture_addr", ram_read_addr, 4);
    chk("s3_capture_valid", prim_valid, 0);
    tick;
    chk("s3_done", {done, prim_valid}, 2'b10);
    start = 0;
    tick;
    ram[4] = 5;
    // zero count
    start = 1; prim_count = 0;
    tick;
    chk("s4_done", {done, busy, prim_valid}, 3'b100);
    chk("s4_addr", ram_read_addr, 0);
    tick;
    chk("s4_hold", {done, prim_valid, ram_read_addr}, {2'b10, 8'd0});
    start = 0;
    tick;
    // reset while presenting
    prim_count = 2; start = 1; prim_ready = 0;
    tick; tick; tick;
    chk("s5_valid", prim_valid, 1);
    reset = 1;
    tick;
    chk("s5_reset", {prim_valid, busy, done}, 0);
    reset = 0;
    tick;
    chk("s5_refetch_addr", {busy, ram_read_addr}, {1'b1, 8'd0});
    tick; tick;
    chk("s5_rec0", {prim_valid, rec(), prim_index}, {1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 8'd0});
    prim_ready = 1;
    tick; tick; tick; tick;
    chk("s5_done", done, 1);
    start = 0; prim_ready = 0;
    tick;
    // randomized record lists, including address wrap and end markers
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < 256; a++) ram[a] = ($urandom % 30 == 0) ? END_MARKER : $urandom;
      n = (it % 5 == 4) ? $urandom_range(60, 90) : $urandom_range(0, 8);
      exp_q.delete();
      exp_sum = 0;
      for (int k = 0; k < n; k++) begin
        int b;
        b = (k * 4) % 256;
        if (ram[b] == END_MARKER) break;
        exp_q.push_back({ram[b], ram[(b + 1) % 256], ram[(b + 2) % 256], ram[(b + 3) % 256]});
        exp_sum = exp_sum ^ ram[b] ^ ram[(b + 1) % 256] ^ ram[(b + 2) % 256] ^ ram[(b + 3) % 256];
      end
      prim_count = 8'(n); start = 1; got = 0; cyc = 0;
      while (!done && cyc < 3000) begin
        prim_ready = $urandom_range(0, 1) == 1;
        if (prim_valid && prim_ready) begin
          r = got < exp_q.size() ? exp_q[got] : '1;
          chk("rnd_rec", rec(), r);
          chk("rnd_idx", prim_index, 8'(got));
          got++;
        end
        tick;
        cyc++;
      end
      chk("rnd_done", done, 1);
      chk("rnd_count", got, exp_q.size());
`ifdef PRIM_FETCH_CHECKSUM_EN
      chk("rnd_checksum", checksum, exp_sum);
`endif
      start = 0; prim_ready = 0;
      tick;
      chk("rnd_idle", {done, busy}, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
